// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MIPS memory stage: access widths, control-bit
// indices and the load-extension/alignment helpers.
package mem_stage_pkg;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  localparam int MEM_BRANCH = 2;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 0;
  localparam int WB_REGWR   = 1;
  localparam int WB_MEM2REG = 0;

  // The reserved width 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lane);
    logic mis;
    case (width)
      W_BYTE:  mis = 1'b0;
      W_HALF:  mis = lane[0];
      default: mis = (lane != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] width, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (width)
      W_BYTE:  res = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      W_HALF:  res = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_memory.sv
// DEPTH x 32 data memory: byte-enable write on the falling edge, asynchronous
// read, optional registered debug read port (MEM_DEBUG_PORT_EN).
module data_memory #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
`ifdef MEM_DEBUG_PORT_EN
  ,
  input  logic [AW-1:0] dbg_addr_i,
  input  logic          dbg_rd_i,
  output logic [31:0]   dbg_data_o
`endif
);

  logic [31:0] mem_q [DEPTH];

  // Byte-lane writes; an edge that coincides with reset drops the write.
  always_ff @(negedge clk) begin
    if (!rst) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

`ifdef MEM_DEBUG_PORT_EN
  logic [31:0] dbg_data_q;

  // Side-effect-free snapshot for the debug unit.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      dbg_data_q <= 32'h0000_0000;
    end else if (dbg_rd_i) begin
      dbg_data_q <= mem_q[dbg_addr_i];
    end else begin
      dbg_data_q <= dbg_data_q;
    end
  end

  assign dbg_data_o = dbg_data_q;
`endif

endmodule

// File: rtl/memory_access.sv
// MEM stage of the MIPS pipeline: branch resolution, aligned byte/half/word
// loads and stores, MEM/WB register. Optional debug port: MEM_DEBUG_PORT_EN.
module memory_access
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  inWB,
  input  logic [2:0]  inMEM,
  input  logic [1:0]  inWidth,
  input  logic        inUnsigned,
  input  logic [31:0] inPCJump,
  input  logic [31:0] inALUResult,
  input  logic        inALUZero,
  input  logic [31:0] inRegB,
  input  logic [4:0]  inRegF_wreg,
  output logic        outPCSrc,
  output logic [31:0] outPCJump,
  output logic [31:0] MEM_AluResult,
  output logic [4:0]  MEM_rd,
  output logic        MEM_regF_wr,
  output logic [1:0]  outWB,
  output logic [31:0] outReadData,
  output logic [31:0] outALUResult,
  output logic [4:0]  outRegF_wreg,
  output logic        outMisaligned
`ifdef MEM_DEBUG_PORT_EN
  ,
  input  logic [AW-1:0] dbg_addr,
  input  logic          dbg_rd,
  output logic [31:0]   dbg_data
`endif
);

  logic [1:0]  lane_s;
  logic [AW-1:0] word_addr_s;
  logic        mem_rd_s, mem_wr_s, mis_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s, rdata_s;

  logic [1:0]  wb_d, wb_q;
  logic [31:0] read_data_d, read_data_q;
  logic [31:0] alu_d, alu_q;
  logic [4:0]  wreg_d, wreg_q;
  logic        mis_d, mis_q;

  assign outPCSrc      = inMEM[MEM_BRANCH] & inALUZero;
  assign outPCJump     = inPCJump;
  assign MEM_AluResult = inALUResult;
  assign MEM_rd        = inRegF_wreg;
  assign MEM_regF_wr   = inWB[WB_REGWR];

  // Access decode: alignment check, store lane enables and MEM/WB next state.
  always_comb begin
    lane_s      = inALUResult[1:0];
    word_addr_s = inALUResult[AW+1:2];
    mem_rd_s    = inMEM[MEM_READ];
    mem_wr_s    = inMEM[MEM_WRITE];
    mis_s       = (mem_rd_s | mem_wr_s) & is_misaligned(inWidth, lane_s);
    be_s        = 4'b0000;
    wdata_s     = inRegB;
    if (mem_wr_s && !mis_s) begin
      case (inWidth)
        W_BYTE: begin
          be_s    = 4'b0001 << lane_s;
          wdata_s = {4{inRegB[7:0]}};
        end
        W_HALF: begin
          be_s    = 4'b0011 << lane_s;
          wdata_s = {2{inRegB[15:0]}};
        end
        default: begin
          be_s    = 4'b1111;
          wdata_s = inRegB;
        end
      endcase
    end else begin
      be_s = 4'b0000;
    end
    // A store shadows a simultaneous read, so the load data is zero then.
    if (mem_rd_s && !mem_wr_s && !mis_s) begin
      read_data_d = extend_load(rdata_s, lane_s, inWidth, inUnsigned);
    end else begin
      read_data_d = 32'h0000_0000;
    end
    wb_d   = {inWB[WB_REGWR] & ~mis_s, inWB[WB_MEM2REG]};
    alu_d  = inALUResult;
    wreg_d = inRegF_wreg;
    mis_d  = mis_s;
  end

  // MEM/WB pipeline register, falling-edge clocked.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      wb_q        <= 2'b00;
      read_data_q <= 32'h0000_0000;
      alu_q       <= 32'h0000_0000;
      wreg_q      <= 5'd0;
      mis_q       <= 1'b0;
    end else begin
      wb_q        <= wb_d;
      read_data_q <= read_data_d;
      alu_q       <= alu_d;
      wreg_q      <= wreg_d;
      mis_q       <= mis_d;
    end
  end

  assign outWB         = wb_q;
  assign outReadData   = read_data_q;
  assign outALUResult  = alu_q;
  assign outRegF_wreg  = wreg_q;
  assign outMisaligned = mis_q;

  data_memory #(.DEPTH(DEPTH), .AW(AW)) u_dmem (
    .clk        (clk),
    .rst        (rst),
    .addr_i     (word_addr_s),
    .be_i       (be_s),
    .wdata_i    (wdata_s),
    .rdata_o    (rdata_s)
`ifdef MEM_DEBUG_PORT_EN
    ,
    .dbg_addr_i (dbg_addr),
    .dbg_rd_i   (dbg_rd),
    .dbg_data_o (dbg_data)
`endif
  );

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: directed accesses push expected MEM/WB
// contents, a monitor pops and compares after each falling edge.
module tb_memory_access;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  inWB;
  logic [2:0]  inMEM;
  logic [1:0]  inWidth;
  logic        inUnsigned;
  logic [31:0] inPCJump, inALUResult, inRegB;
  logic        inALUZero;
  logic [4:0]  inRegF_wreg;
  logic        outPCSrc, MEM_regF_wr, outMisaligned;
  logic [31:0] outPCJump, MEM_AluResult, outReadData, outALUResult;
  logic [4:0]  MEM_rd, outRegF_wreg;
  logic [1:0]  outWB;
`ifdef MEM_DEBUG_PORT_EN
  logic [7:0]  dbg_addr;
  logic        dbg_rd;
  logic [31:0] dbg_data;
`endif

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  memory_access dut (
    .clk(clk), .rst(rst), .inWB(inWB), .inMEM(inMEM), .inWidth(inWidth),
    .inUnsigned(inUnsigned), .inPCJump(inPCJump), .inALUResult(inALUResult),
    .inALUZero(inALUZero), .inRegB(inRegB), .inRegF_wreg(inRegF_wreg),
    .outPCSrc(outPCSrc), .outPCJump(outPCJump), .MEM_AluResult(MEM_AluResult),
    .MEM_rd(MEM_rd), .MEM_regF_wr(MEM_regF_wr), .outWB(outWB),
    .outReadData(outReadData), .outALUResult(outALUResult),
    .outRegF_wreg(outRegF_wreg), .outMisaligned(outMisaligned)
`ifdef MEM_DEBUG_PORT_EN
    , .dbg_addr(dbg_addr), .dbg_rd(dbg_rd), .dbg_data(dbg_data)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one operation just after the rising edge, check the combinational
  // taps, and queue the registered result expected after the next falling edge.
  task automatic issue(input logic [1:0] wb, input logic [2:0] mem, input logic [1:0] width,
                       input logic uns, input logic [31:0] addr, input logic [31:0] regb,
                       input logic [4:0] rd, input logic [1:0] e_wb, input logic [31:0] e_rdata,
                       input logic e_mis, input logic zero = 1'b0,
                       input logic [31:0] pcj = 32'h0040_0000, input logic e_pcsrc = 1'b0);
    exp_t e;
    @(posedge clk);
    inWB = wb; inMEM = mem; inWidth = width; inUnsigned = uns;
    inALUResult = addr; inRegB = regb; inRegF_wreg = rd;
    inALUZero = zero; inPCJump = pcj;
    e.wb = e_wb; e.rdata = e_rdata; e.alu = addr; e.rd = rd; e.mis = e_mis;
    exp_q.push_back(e);
    #1;
    chk("pcsrc", {31'd0, outPCSrc}, {31'd0, e_pcsrc});
    chk("pcjump", outPCJump, pcj);
    chk("fwd_alu", MEM_AluResult, addr);
    chk("fwd_rd", {27'd0, MEM_rd}, {27'd0, rd});
    chk("fwd_wr", {31'd0, MEM_regF_wr}, {31'd0, wb[1]});
  endtask

  // Monitor: the stage presents a result every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst && exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("outWB", {30'd0, outWB}, {30'd0, mon_e.wb});
        chk("outReadData", outReadData, mon_e.rdata);
        chk("outALUResult", outALUResult, mon_e.alu);
        chk("outRegF_wreg", {27'd0, outRegF_wreg}, {27'd0, mon_e.rd});
        chk("outMisaligned", {31'd0, outMisaligned}, {31'd0, mon_e.mis});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    inWB = 2'b00; inMEM = 3'b000; inWidth = W_WORD; inUnsigned = 1'b0;
    inPCJump = 32'h0; inALUResult = 32'h0; inALUZero = 1'b0;
    inRegB = 32'h0; inRegF_wreg = 5'd0;
`ifdef MEM_DEBUG_PORT_EN
    dbg_addr = 8'd0; dbg_rd = 1'b0;
`endif
    #3;
    chk("rst_outWB", {30'd0, outWB}, 32'd0);
    chk("rst_rdata", outReadData, 32'd0);
    chk("rst_alu", outALUResult, 32'd0);
    chk("rst_wreg", {27'd0, outRegF_wreg}, 32'd0);
    chk("rst_mis", {31'd0, outMisaligned}, 32'd0);
    rst = 1'b0;

    //     wb     mem     width  uns   addr          regb          rd    e_wb   e_rdata       e_mis
    issue(2'b00, 3'b001, W_WORD, 1'b0, 32'h10,  32'hDEADBEEF, 5'd0, 2'b00, 32'h0,        1'b0);
    issue(2'b11, 3'b010, W_WORD, 1'b0, 32'h10,  32'h0,        5'd5, 2'b11, 32'hDEADBEEF, 1'b0);
    issue(2'b11, 3'b010, W_BYTE, 1'b0, 32'h13,  32'h0,        5'd6, 2'b11, 32'hFFFFFFDE, 1'b0);
    issue(2'b11, 3'b010, W_BYTE, 1'b1, 32'h13,  32'h0,        5'd6, 2'b11, 32'h000000DE, 1'b0);
    issue(2'b00, 3'b001, W_HALF, 1'b0, 32'h12,  32'hAAAA1234, 5'd0, 2'b00, 32'h0,        1'b0);
    issue(2'b11, 3'b010, W_WORD, 1'b0, 32'h10,  32'h0,        5'd7, 2'b11, 32'h1234BEEF, 1'b0);
    issue(2'b11, 3'b010, W_HALF, 1'b0, 32'h12,  32'h0,        5'd8, 2'b11, 32'h00001234, 1'b0);
    issue(2'b11, 3'b010, W_HALF, 1'b0, 32'h10,  32'h0,        5'd8, 2'b11, 32'hFFFFBEEF, 1'b0);
    issue(2'b11, 3'b010, W_HALF, 1'b1, 32'h10,  32'h0,        5'd8, 2'b11, 32'h0000BEEF, 1'b0);
    issue(2'b11, 3'b010, W_WORD, 1'b0, 32'h06,  32'h0,        5'd9, 2'b01, 32'h0,        1'b1);
    issue(2'b00, 3'b000, W_WORD, 1'b0, 32'h0,   32'h0,        5'd0, 2'b00, 32'h0,        1'b0);
`ifdef MEM_DEBUG_PORT_EN
    @(posedge clk);
    dbg_addr = 8'd4; dbg_rd = 1'b1;
    @(negedge clk);
    #2;
    chk("dbg_data", dbg_data, 32'h1234BEEF);
    dbg_rd = 1'b0;
`endif
    issue(2'b00, 3'b001, W_WORD, 1'b0, 32'h12,  32'hFFFFFFFF, 5'd0, 2'b00, 32'h0,        1'b1);
    issue(2'b00, 3'b001, W_HALF, 1'b0, 32'h11,  32'hFFFFFFFF, 5'd0, 2'b00, 32'h0,        1'b1);
    issue(2'b11, 3'b010, W_WORD, 1'b0, 32'h10,  32'h0,        5'd3, 2'b11, 32'h1234BEEF, 1'b0);
    issue(2'b11, 3'b011, W_WORD, 1'b0, 32'h20,  32'h00000055, 5'd2, 2'b11, 32'h0,        1'b0);
    issue(2'b11, 3'b010, W_WORD, 1'b0, 32'h20,  32'h0,        5'd4, 2'b11, 32'h00000055, 1'b0);
    issue(2'b00, 3'b001, W_BYTE, 1'b0, 32'h21,  32'h12345681, 5'd0, 2'b00, 32'h0,        1'b0);
    issue(2'b11, 3'b010, W_BYTE, 1'b0, 32'h21,  32'h0,        5'd4, 2'b11, 32'hFFFFFF81, 1'b0);
    issue(2'b11, 3'b010, W_WORD, 1'b0, 32'h20,  32'h0,        5'd4, 2'b11, 32'h00008155, 1'b0);
    issue(2'b11, 3'b010, W_WORD, 1'b0, 32'h410, 32'h0,        5'd1, 2'b11, 32'h1234BEEF, 1'b0);
    issue(2'b11, 3'b010, 2'b11,  1'b0, 32'h10,  32'h0,        5'd1, 2'b11, 32'h1234BEEF, 1'b0);
    issue(2'b10, 3'b000, W_WORD, 1'b0, 32'h10,  32'h0,        5'd1, 2'b10, 32'h0,        1'b0);
    // branch resolution: taken, then not taken
    issue(2'b00, 3'b100, W_WORD, 1'b0, 32'h0,   32'h0,        5'd0, 2'b00, 32'h0,        1'b0,
          1'b1, 32'h0040_0080, 1'b1);
    issue(2'b00, 3'b100, W_WORD, 1'b0, 32'h4,   32'h0,        5'd0, 2'b00, 32'h0,        1'b0,
          1'b0, 32'h0040_0100, 1'b0);
    issue(2'b11, 3'b010, W_WORD, 1'b0, 32'h10,  32'h0,        5'd7, 2'b11, 32'h1234BEEF, 1'b0);

    @(negedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    // Mid-cycle reset with a load still driving nonzero results.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_outWB", {30'd0, outWB}, 32'd0);
    chk("midrst_rdata", outReadData, 32'd0);
    chk("midrst_alu", outALUResult, 32'd0);
    chk("midrst_wreg", {27'd0, outRegF_wreg}, 32'd0);
    chk("midrst_mis", {31'd0, outMisaligned}, 32'd0);
`ifdef MEM_DEBUG_PORT_EN
    chk("midrst_dbg", dbg_data, 32'd0);
`endif
    @(posedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
